sram_fifo_controller: RTL and testbench

- Synchronous FIFO controller that uses one region of the 8-bit 4-port SRAM as a circular buffer.
- Drives SRAM write port A (data, address, write enable) and read port C (address, read enable), and consumes read port C data.
- Presents a valid/ready push interface and a request/valid pop interface to the rest of the design.
- All logic is on the rising edge of `Clk_In`; the SRAM acts on the falling edge of the same clock.

---
 rtl/sram_fifo_controller_if.sv | 30 +++
 rtl/sram_fifo_controller.sv | 112 +++++++++++
 tb/tb_sram_fifo_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_controller_if.sv
// Push/pop and status bundle between a FIFO client (master) and sram_fifo_controller (slave).
interface sram_fifo_controller_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    Push_Data_In;
    logic          Push_Valid_In;
    logic          Push_Ready_Out;
    logic          Pop_Request_In;
    logic [7:0]    Pop_Data_Out;
    logic          Pop_Valid_Out;
    logic          Full_Out;
    logic          Empty_Out;
    logic [CW-1:0] Count_Out;
    logic          Overflow_Out;
    logic          Underflow_Out;

    modport slave (
        input  Push_Data_In, Push_Valid_In, Pop_Request_In,
        output Push_Ready_Out, Pop_Data_Out, Pop_Valid_Out,
               Full_Out, Empty_Out, Count_Out, Overflow_Out, Underflow_Out
    );

    modport master (
        output Push_Data_In, Push_Valid_In, Pop_Request_In,
        input  Push_Ready_Out, Pop_Data_Out, Pop_Valid_Out,
               Full_Out, Empty_Out, Count_Out, Overflow_Out, Underflow_Out
    );
endinterface

// File: rtl/sram_fifo_controller.sv
// Circular-buffer FIFO over one SRAM region: write port A for pushes, read port C for pops.
// Pop latency 1 cycle; push back-pressured by Full_Out, pops from empty are dropped and flagged.
module sram_fifo_controller #(
    parameter int DEPTH     = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    sram_fifo_controller_if.slave  fifo_if,
    output logic [7:0]             SRAM_Write_Data_Out,
    output logic [7:0]             SRAM_Write_Address_Out,
    output logic                   SRAM_Write_Enable_Out,
    output logic [7:0]             SRAM_Read_Address_Out,
    output logic                   SRAM_Read_Enable_Out,
    input  logic [7:0]             SRAM_Read_Data_In
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [7:0]    BASE_C  = 8'(BASE_ADDR);

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_pending_q, rd_pending_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    waddr_q, waddr_d;
    logic          we_q, we_d;
    logic [7:0]    raddr_q, raddr_d;
    logic [7:0]    pop_data_q, pop_data_d;
    logic          pop_vld_q, pop_vld_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          full, empty, push_acc, pop_acc;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    always_comb begin
        push_acc = fifo_if.Push_Valid_In && !full;
        pop_acc  = fifo_if.Pop_Request_In && !empty;

        wp_d    = push_acc ? wp_q + PW'(1) : wp_q;
        rp_d    = pop_acc  ? rp_q + PW'(1) : rp_q;
        count_d = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wdata_d = push_acc ? fifo_if.Push_Data_In : wdata_q;
        waddr_d = push_acc ? BASE_C + 8'(wp_q) : waddr_q;
        we_d    = push_acc;

        raddr_d      = pop_acc ? BASE_C + 8'(rp_q) : raddr_q;
        rd_pending_d = pop_acc;

        // Port C floats while not enabled, so only capture on the cycle after a read issue.
        pop_data_d = rd_pending_q ? SRAM_Read_Data_In : pop_data_q;
        pop_vld_d  = rd_pending_q;

        ovf_d = ovf_q | (fifo_if.Push_Valid_In & full);
        unf_d = unf_q | (fifo_if.Pop_Request_In & empty);
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            rd_pending_q <= 1'b0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            raddr_q      <= '0;
            pop_data_q   <= '0;
            pop_vld_q    <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            rd_pending_q <= rd_pending_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            raddr_q      <= raddr_d;
            pop_data_q   <= pop_data_d;
            pop_vld_q    <= pop_vld_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Read enable and the pending-capture flag are the same registered event.
    assign SRAM_Read_Enable_Out   = rd_pending_q;
    assign SRAM_Read_Address_Out  = raddr_q;
    assign SRAM_Write_Data_Out    = wdata_q;
    assign SRAM_Write_Address_Out = waddr_q;
    assign SRAM_Write_Enable_Out  = we_q;

    assign fifo_if.Push_Ready_Out = !full;
    assign fifo_if.Full_Out       = full;
    assign fifo_if.Empty_Out      = empty;
    assign fifo_if.Count_Out      = count_q;
    assign fifo_if.Pop_Data_Out   = pop_data_q;
    assign fifo_if.Pop_Valid_Out  = pop_vld_q;
    assign fifo_if.Overflow_Out   = ovf_q;
    assign fifo_if.Underflow_Out  = unf_q;
endmodule

// File: tb/tb_sram_fifo_controller.sv
// Directed bench: two controllers (16 deep at 0x00, 4 deep at 0x40), each with its own SRAM model.
module tb_sram_fifo_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst_a, rst_b;
    logic [7:0] wdata_a, waddr_a, raddr_a, rdata_a;
    logic       we_a, re_a;
    logic [7:0] wdata_b, waddr_b, raddr_b, rdata_b;
    logic       we_b, re_b;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    sram_fifo_controller_if #(.DEPTH(16)) ifa ();
    sram_fifo_controller_if #(.DEPTH(4))  ifb ();

    sram_fifo_controller #(.DEPTH(16), .BASE_ADDR(0)) dut_a (
        .Clk_In(clk), .Reset_In(rst_a), .fifo_if(ifa),
        .SRAM_Write_Data_Out(wdata_a), .SRAM_Write_Address_Out(waddr_a),
        .SRAM_Write_Enable_Out(we_a), .SRAM_Read_Address_Out(raddr_a),
        .SRAM_Read_Enable_Out(re_a), .SRAM_Read_Data_In(rdata_a)
    );

    sram_fifo_controller #(.DEPTH(4), .BASE_ADDR(8'h40)) dut_b (
        .Clk_In(clk), .Reset_In(rst_b), .fifo_if(ifb),
        .SRAM_Write_Data_Out(wdata_b), .SRAM_Write_Address_Out(waddr_b),
        .SRAM_Write_Enable_Out(we_b), .SRAM_Read_Address_Out(raddr_b),
        .SRAM_Read_Enable_Out(re_b), .SRAM_Read_Data_In(rdata_b)
    );

    // SRAM models act on the falling edge; the read port floats when not enabled.
    always @(negedge clk) begin
        if (we_a) mem_a[waddr_a] <= wdata_a;
        rdata_a <= re_a ? mem_a[raddr_a] : 8'hzz;
        if (we_b) mem_b[waddr_b] <= wdata_b;
        rdata_b <= re_b ? mem_b[raddr_b] : 8'hzz;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d);
        ifa.Push_Valid_In = 1'b1;
        ifa.Push_Data_In  = d;
        cyc();
        ifa.Push_Valid_In = 1'b0;
    endtask

    logic [7:0] exp_q [5];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.Push_Data_In = '0; ifa.Push_Valid_In = 1'b0; ifa.Pop_Request_In = 1'b0;
        ifb.Push_Data_In = '0; ifb.Push_Valid_In = 1'b0; ifb.Pop_Request_In = 1'b0;
        cyc();
        cyc();
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state
        chk("rst_count", 32'(ifa.Count_Out), 0);
        chk("rst_empty", 32'(ifa.Empty_Out), 1);
        chk("rst_full", 32'(ifa.Full_Out), 0);
        chk("rst_ready", 32'(ifa.Push_Ready_Out), 1);
        chk("rst_pvld", 32'(ifa.Pop_Valid_Out), 0);
        chk("rst_pdata", 32'(ifa.Pop_Data_Out), 0);
        chk("rst_ovf", 32'(ifa.Overflow_Out), 0);
        chk("rst_unf", 32'(ifa.Underflow_Out), 0);
        chk("rst_we", 32'(we_a), 0);
        chk("rst_re", 32'(re_a), 0);
        chk("rst_b_count", 32'(ifb.Count_Out), 0);
        chk("rst_b_empty", 32'(ifb.Empty_Out), 1);

        // Basic push 3 / pop 3
        for (int i = 0; i < 3; i++) begin
            ifa.Push_Valid_In = 1'b1;
            ifa.Push_Data_In  = 8'(8'h11 * (i + 1));
            cyc();
            chk("basic_we", 32'(we_a), 1);
            chk("basic_waddr", 32'(waddr_a), 32'(i));
            chk("basic_wdata", 32'(wdata_a), 32'(8'h11 * (i + 1)));
            chk("basic_count_up", 32'(ifa.Count_Out), 32'(i + 1));
        end
        ifa.Push_Valid_In  = 1'b0;
        ifa.Pop_Request_In = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("basic_re", 32'(re_a), 1);
            chk("basic_raddr", 32'(raddr_a), 32'(i));
            chk("basic_count_dn", 32'(ifa.Count_Out), 32'(2 - i));
            if (i == 0) chk("basic_no_early_vld", 32'(ifa.Pop_Valid_Out), 0);
            else begin
                chk("basic_pvld", 32'(ifa.Pop_Valid_Out), 1);
                chk("basic_pdata", 32'(ifa.Pop_Data_Out), 32'(8'h11 * i));
            end
        end
        ifa.Pop_Request_In = 1'b0;
        cyc();
        chk("basic_pvld_last", 32'(ifa.Pop_Valid_Out), 1);
        chk("basic_pdata_last", 32'(ifa.Pop_Data_Out), 32'h33);
        chk("basic_re_off", 32'(re_a), 0);
        chk("basic_empty", 32'(ifa.Empty_Out), 1);
        cyc();
        chk("basic_pvld_pulse", 32'(ifa.Pop_Valid_Out), 0);
        chk("basic_pdata_hold", 32'(ifa.Pop_Data_Out), 32'h33);

        // Underflow after reset
        reset_a();
        chk("unf_clear", 32'(ifa.Underflow_Out), 0);
        ifa.Pop_Request_In = 1'b1;
        cyc();
        ifa.Pop_Request_In = 1'b0;
        chk("unf_set", 32'(ifa.Underflow_Out), 1);
        chk("unf_no_re", 32'(re_a), 0);
        cyc();
        chk("unf_no_pvld", 32'(ifa.Pop_Valid_Out), 0);
        chk("unf_sticky", 32'(ifa.Underflow_Out), 1);
        chk("unf_count", 32'(ifa.Count_Out), 0);

        // Fill to 16, then overflow
        reset_a();
        for (int i = 0; i < 16; i++) push_a(8'(i));
        chk("full_count", 32'(ifa.Count_Out), 16);
        chk("full_flag", 32'(ifa.Full_Out), 1);
        chk("full_ready", 32'(ifa.Push_Ready_Out), 0);
        chk("full_ovf_pre", 32'(ifa.Overflow_Out), 0);
        push_a(8'hEE);
        chk("ovf_set", 32'(ifa.Overflow_Out), 1);
        chk("ovf_no_we", 32'(we_a), 0);
        chk("ovf_count", 32'(ifa.Count_Out), 16);
        // Push+pop while full: pop proceeds, push rejected
        ifa.Push_Valid_In = 1'b1; ifa.Push_Data_In = 8'hEE; ifa.Pop_Request_In = 1'b1;
        cyc();
        ifa.Push_Valid_In = 1'b0; ifa.Pop_Request_In = 1'b0;
        chk("fullpp_we", 32'(we_a), 0);
        chk("fullpp_re", 32'(re_a), 1);
        chk("fullpp_count", 32'(ifa.Count_Out), 15);
        cyc();
        chk("fullpp_pdata", 32'(ifa.Pop_Data_Out), 32'h00);

        // Simultaneous push/pop with count=2
        reset_a();
        push_a(8'h01);
        push_a(8'h02);
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'hAA; exp_q[3] = 8'hAA; exp_q[4] = 8'hAA;
        ifa.Push_Valid_In = 1'b1; ifa.Push_Data_In = 8'hAA; ifa.Pop_Request_In = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("pp_count", 32'(ifa.Count_Out), 2);
            chk("pp_we", 32'(we_a), 1);
            if (k > 0) chk("pp_pdata", 32'(ifa.Pop_Data_Out), 32'(exp_q[k-1]));
        end
        ifa.Push_Valid_In = 1'b0; ifa.Pop_Request_In = 1'b0;
        cyc();
        chk("pp_pdata_last", 32'(ifa.Pop_Data_Out), 32'(exp_q[4]));
        chk("pp_pvld_last", 32'(ifa.Pop_Valid_Out), 1);

        // Reset with a pop in flight
        reset_a();
        push_a(8'h77);
        push_a(8'h88);
        ifa.Pop_Request_In = 1'b1;
        cyc();
        ifa.Pop_Request_In = 1'b0;
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        chk("rstpop_pvld", 32'(ifa.Pop_Valid_Out), 0);
        chk("rstpop_count", 32'(ifa.Count_Out), 0);
        chk("rstpop_empty", 32'(ifa.Empty_Out), 1);
        chk("rstpop_re", 32'(re_a), 0);
        cyc();
        chk("rstpop_pvld_after", 32'(ifa.Pop_Valid_Out), 0);
        push_a(8'h5C);
        chk("rstpop_waddr", 32'(waddr_a), 0);
        ifa.Pop_Request_In = 1'b1;
        cyc();
        ifa.Pop_Request_In = 1'b0;
        chk("rstpop_raddr", 32'(raddr_a), 0);
        cyc();
        chk("rstpop_pvld2", 32'(ifa.Pop_Valid_Out), 1);
        chk("rstpop_pdata", 32'(ifa.Pop_Data_Out), 32'h5C);

        // Wrap-around on the 4-deep instance at 0x40
        for (int i = 0; i < 8; i++) begin
            ifb.Push_Valid_In  = (i < 6);
            ifb.Push_Data_In   = 8'(8'hC0 + i);
            ifb.Pop_Request_In = (i >= 2);
            cyc();
            chk("wrap_count_max", 32'(ifb.Count_Out <= 3), 1);
            if (i < 6) chk("wrap_waddr", 32'(waddr_b), 32'(8'h40 + (i % 4)));
            if (i >= 2) chk("wrap_raddr", 32'(raddr_b), 32'(8'h40 + ((i - 2) % 4)));
            if (i >= 3) begin
                chk("wrap_pvld", 32'(ifb.Pop_Valid_Out), 1);
                chk("wrap_pdata", 32'(ifb.Pop_Data_Out), 32'(8'hC0 + (i - 3)));
            end
        end
        ifb.Push_Valid_In = 1'b0; ifb.Pop_Request_In = 1'b0;
        cyc();
        chk("wrap_pdata_last", 32'(ifb.Pop_Data_Out), 32'hC5);
        chk("wrap_count_end", 32'(ifb.Count_Out), 0);
        chk("wrap_empty_end", 32'(ifb.Empty_Out), 1);
        chk("wrap_ovf", 32'(ifb.Overflow_Out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
